ctrl_pipe_chain: RTL and testbench
==================================

// Module: ctrl_pipe_chain
// PURPOSE
//  Parametrised successor to the fixed inter-stage control registers: a DEPTH-deep chain of control-word slots.
//  Each slot carries a WIDTH-bit control word (e.g. {RegWrite, MemWrite, ResultSrc}) plus a valid bit.
//  Adds valid/ready back-pressure, per-slot flush (bubble insert) and optional bubble collapsing.
//  Also exports occupancy and a killed-entry counter. Sits between decode and writeback, driven by the hazard unit.
// PARAMETERS
//  WIDTH     4   control-word width in bits (>=1)
//  DEPTH     2   number of slots (>=1); slot 0 = input side, slot DEPTH-1 = output
//  COLLAPSE  0   0: lockstep, all slots shift together; 1: each slot advances independently, squeezing bubbles
//  CNT_W     16  width of kill_count
// PORTS
//  clk          in   1           rising-edge clock
//  reset        in   1           synchronous, active-high reset
//  in_valid     in   1           control word offered at slot 0
//  in_data      in   WIDTH       control word
//  in_ready     out  1           slot 0 accepts this cycle (combinational)
//  flush        in   DEPTH       flush[i]: slot i becomes a bubble next cycle
//  out_valid    out  1           slot DEPTH-1 holds a valid word
//  out_data     out  WIDTH       slot DEPTH-1 word; all-zero whenever out_valid=0
//  out_ready    in   1           consumer takes the output word this cycle
//  stage_valid  out  DEPTH       registered valid bit of every slot (for hazard/forwarding)
//  occupancy    out  $clog2(DEPTH+1)  registered count of valid slots
//  kill_count   out  CNT_W       saturating count of valid words discarded by flush
// BEHAVIOUR
//  Reset is synchronous and has highest priority.
//  On reset: all valid bits 0, all slot data 0, occupancy 0, kill_count 0. So out_valid=0, out_data=0, stage_valid=0.
//  Definitions:
//   take[i] = slot i loads from its upstream (in_* for i=0)
//   go[i]   = slot i's word leaves: go[DEPTH-1] = valid & out_ready; go[i] = take[i+1] & valid[i]
//  COLLAPSE=0 (lockstep): adv = out_ready | ~valid[DEPTH-1].
//   take[i] = adv for every slot; in_ready = adv.
//   When adv=0 all slots hold.
//  COLLAPSE=1: slot i can load when ~valid[i] | go[i] (evaluated from output side backwards).
//   in_ready = that term for slot 0. A bubble in slot i lets slots <i advance while slots >i stall.
//  Load: when take[i], slot i next = upstream {valid, data}; an invalid upstream loads valid=0, data=0.
//  Hold: slot i keeps its content when not taking.
//  Flush (overrides load and hold): flush[i]=1 -> slot i next valid=0, data=0.
//   The word currently in slot i still leaves normally if go[i]=1; flush only affects the register's next value.
//   flush[0] with in_valid&in_ready: input is accepted (handshake completes) and dropped.
//  Latency: with no stalls/flushes a word accepted in cycle t appears on out_* in cycle t+DEPTH. Throughput 1/cycle.
//  Invariant: slot data is 0 whenever its valid bit is 0.
//  Occupancy: next value = popcount(next valid vector); always equals popcount(stage_valid).
//  kill_count: each cycle adds the number of killed words, saturating at 2^CNT_W-1 (never wraps):
//   killed = sum over i of (valid[i] & flush[i] & ~go[i]) + (in_valid & in_ready & flush[0]).
//  Simultaneous events:
//   - out_ready with flush[DEPTH-1]: word is delivered and not counted; slot becomes empty.
//   - reset with anything: reset wins; no kill counted.
//  Reset mid-operation: all in-flight words are discarded silently; first valid output can appear DEPTH cycles after reset deasserts.
//  No combinational path from in_data to out_data; in_ready depends combinationally on out_ready, flush does not.
// STRUCTURE
//  Shared constants header: control-word field offsets/widths (REGWRITE_BIT, MEMWRITE_BIT, RESULTSRC_LSB/W) and
//   RESULTSRC encodings, so stage users slice words consistently; no block-local typedefs.
//  One sub-module: ctrl_pipe_slot (one valid+data register with take/flush/reset priority), generated DEPTH times.
//  Top level: take/go chain, lockstep/collapse select, popcount, saturating kill counter.
// TESTING
//  1 DEPTH=3,COLLAPSE=0, out_ready=1, words 1,2,3 back-to-back -> out_data 1,2,3 in cycles 3,4,5; occupancy peaks at 3.
//  2 COLLAPSE=0, pipe full (A,B,C), out_ready=0 for 2 cycles -> in_ready=0, all hold; out_ready=1 -> A,B,C in order, none lost.
//  3 COLLAPSE=1, slots {v,0,v}, out_ready=0, in_valid=1 -> slot0 moves into slot1, new word enters slot0, in_ready=1;
//    next cycle in_ready=0.
//  4 Full pipe, flush=3'b010 with out_ready=0 -> slot1 cleared to data 0, kill_count+1, occupancy 3->2.
//    flush[2] with out_ready=1 -> word delivered, kill_count unchanged.
//  5 CNT_W=2, flush[0] with accepted input for 5 cycles -> kill_count 1,2,3,3,3 (saturates).
//  6 Reset asserted while 3 words in flight -> next cycle stage_valid=0, out_data=0, occupancy=0, kill_count=0.

Source files
------------

// File: rtl/ctrl_pipe_chain_pkg.sv
// rtl/ctrl_pipe_chain_pkg.sv - shared control-word layout and sizing helpers for the control pipe chain
// Contents:
//   CTRL_W                 default control-word width
//   REGWRITE_BIT etc.      field positions inside a control word
//   RESULTSRC_*            result-source encodings
//   ctrlWord_t             packed view of the default control word
//   occWidth()             width needed to count 0..depth valid slots
package ctrl_pipe_chain_pkg;

    localparam int CTRL_W        = 4;

    localparam int REGWRITE_BIT  = 3;
    localparam int MEMWRITE_BIT  = 2;
    localparam int RESULTSRC_LSB = 0;
    localparam int RESULTSRC_W   = 2;

    localparam logic [RESULTSRC_W-1:0] RESULTSRC_ALU = 2'b00;
    localparam logic [RESULTSRC_W-1:0] RESULTSRC_MEM = 2'b01;
    localparam logic [RESULTSRC_W-1:0] RESULTSRC_PC4 = 2'b10;
    localparam logic [RESULTSRC_W-1:0] RESULTSRC_IMM = 2'b11;

    typedef struct packed {
        logic                   regWrite;
        logic                   memWrite;
        logic [RESULTSRC_W-1:0] resultSrc;
    } ctrlWord_t;

    function automatic int occWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ctrl_pipe_chain_if.sv
// rtl/ctrl_pipe_chain_if.sv - input/output handshake bundle of the control pipe chain
// Signals:
//   in_valid/in_data/in_ready     producer side (decode) into slot 0
//   out_valid/out_data/out_ready  consumer side (writeback) from the last slot
// Modports:
//   master  drives words in and accepts words out (producer/consumer side)
//   slave   the pipe itself
interface ctrl_pipe_chain_if
    import ctrl_pipe_chain_pkg::*;
#(
    parameter int WIDTH = CTRL_W
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ctrl_pipe_slot.sv
// rtl/ctrl_pipe_slot.sv - one valid+data control-word register with reset > flush > take > hold priority
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   take                load from upstream this cycle
//   flush               become a bubble next cycle (beats take)
//   upValid, upData     upstream word
//   valid, data         registered slot content (data is zero whenever valid is zero)
//   nxtValid            next-state valid bit, exported so the parent can count occupancy
module ctrl_pipe_slot
    import ctrl_pipe_chain_pkg::*;
#(
    parameter int WIDTH = CTRL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             take,
    input  logic             flush,
    input  logic             upValid,
    input  logic [WIDTH-1:0] upData,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             nxtValid
);
    logic [WIDTH-1:0] nxtData;

    always_comb begin
        nxtValid = valid;
        nxtData  = data;
        if (flush) begin
            nxtValid = 1'b0;
            nxtData  = '0;
        end else if (take) begin
            nxtValid = upValid;
            // Bubbles are stored as zero so downstream users never see stale fields.
            nxtData  = upValid ? upData : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= nxtValid;
            data  <= nxtData;
        end
    end
endmodule

// File: rtl/ctrl_pipe_chain.sv
// rtl/ctrl_pipe_chain.sv - DEPTH-deep control-word pipe with back-pressure, per-slot flush and optional bubble collapsing
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   bus            slave handshake bundle (in_* into slot 0, out_* from slot DEPTH-1)
//   flush          per-slot bubble insert
//   stage_valid    registered valid bit of every slot
//   occupancy      registered count of valid slots
//   kill_count     saturating count of valid words discarded by flush
module ctrl_pipe_chain
    import ctrl_pipe_chain_pkg::*;
#(
    parameter int WIDTH    = CTRL_W,
    parameter int DEPTH    = 2,
    parameter int COLLAPSE = 0,
    parameter int CNT_W    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    ctrl_pipe_chain_if.slave               bus,
    input  logic [DEPTH-1:0]               flush,
    output logic [DEPTH-1:0]               stage_valid,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy,
    output logic [CNT_W-1:0]               kill_count
);
    localparam int OCC_W = occWidth(DEPTH);
    localparam int KW    = $clog2(DEPTH + 2);
    localparam int SUM_W = ((CNT_W > KW) ? CNT_W : KW) + 1;
    localparam logic [CNT_W-1:0] KILL_MAX = '1;

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] nxtValid;
    logic [DEPTH-1:0] take;
    logic [DEPTH-1:0] go;
    logic [WIDTH-1:0] slotData [DEPTH];

    // take/go chain, resolved from the output side backwards so a stalled
    // consumer propagates towards the input within the same cycle.
    always_comb begin
        take = '0;
        go   = '0;
        go[DEPTH-1] = valid[DEPTH-1] & bus.out_ready;
        if (COLLAPSE == 0) begin
            take = {DEPTH{bus.out_ready | ~valid[DEPTH-1]}};
            for (int i = 0; i < DEPTH - 1; i++) begin
                go[i] = take[i+1] & valid[i];
            end
        end else begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                take[i] = ~valid[i] | go[i];
                if (i > 0) begin
                    go[i-1] = take[i] & valid[i-1];
                end
            end
        end
    end

    assign bus.in_ready = take[0];

    for (genvar g = 0; g < DEPTH; g++) begin : gSlot
        logic             upValid;
        logic [WIDTH-1:0] upData;

        if (g == 0) begin : gHead
            assign upValid = bus.in_valid;
            assign upData  = bus.in_data;
        end else begin : gBody
            assign upValid = valid[g-1];
            assign upData  = slotData[g-1];
        end

        ctrl_pipe_slot #(
            .WIDTH (WIDTH)
        ) uSlot (
            .clk      (clk),
            .reset    (reset),
            .take     (take[g]),
            .flush    (flush[g]),
            .upValid  (upValid),
            .upData   (upData),
            .valid    (valid[g]),
            .data     (slotData[g]),
            .nxtValid (nxtValid[g])
        );
    end

    assign bus.out_valid = valid[DEPTH-1];
    assign bus.out_data  = slotData[DEPTH-1];
    assign stage_valid   = valid;

    logic [OCC_W-1:0] occNext;
    logic [KW-1:0]    killed;
    logic [SUM_W-1:0] killSum;

    // A word only counts as killed if flush removes it before it could leave;
    // a word leaving through go[i] while its slot is flushed is delivered.
    always_comb begin
        occNext = '0;
        killed  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occNext = occNext + OCC_W'(nxtValid[i]);
            killed  = killed + KW'(valid[i] & flush[i] & ~go[i]);
        end
        killed  = killed + KW'(bus.in_valid & take[0] & flush[0]);
        killSum = SUM_W'(kill_count) + SUM_W'(killed);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy  <= '0;
            kill_count <= '0;
        end else begin
            occupancy  <= occNext;
            kill_count <= (killSum > SUM_W'(KILL_MAX)) ? KILL_MAX : killSum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb/tb_ctrl_pipe_chain.sv - self-checking bench: lockstep, collapsing and narrow-counter pipes against a reference model
module tb_ctrl_pipe_chain;
    localparam int W  = 4;
    localparam int D  = 3;
    localparam int NM = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [D-1:0] flush;
    logic         inValid;
    logic [W-1:0] inData;
    logic         outReady;

    ctrl_pipe_chain_if #(.WIDTH(W)) ifA ();
    ctrl_pipe_chain_if #(.WIDTH(W)) ifB ();
    ctrl_pipe_chain_if #(.WIDTH(W)) ifC ();

    assign ifA.in_valid = inValid;  assign ifA.in_data = inData;  assign ifA.out_ready = outReady;
    assign ifB.in_valid = inValid;  assign ifB.in_data = inData;  assign ifB.out_ready = outReady;
    assign ifC.in_valid = inValid;  assign ifC.in_data = inData;  assign ifC.out_ready = outReady;

    logic [D-1:0] svA, svB, svC;
    logic [1:0]   occA, occB, occC;
    logic [15:0]  kcA, kcB;
    logic [1:0]   kcC;

    ctrl_pipe_chain #(.WIDTH(W), .DEPTH(D), .COLLAPSE(0), .CNT_W(16)) dutA (
        .clk(clk), .reset(reset), .bus(ifA.slave), .flush(flush),
        .stage_valid(svA), .occupancy(occA), .kill_count(kcA));
    ctrl_pipe_chain #(.WIDTH(W), .DEPTH(D), .COLLAPSE(1), .CNT_W(16)) dutB (
        .clk(clk), .reset(reset), .bus(ifB.slave), .flush(flush),
        .stage_valid(svB), .occupancy(occB), .kill_count(kcB));
    ctrl_pipe_chain #(.WIDTH(W), .DEPTH(D), .COLLAPSE(0), .CNT_W(2)) dutC (
        .clk(clk), .reset(reset), .bus(ifC.slave), .flush(flush),
        .stage_valid(svC), .occupancy(occC), .kill_count(kcC));

    logic         dRdy [NM];
    logic         dOv  [NM];
    logic [W-1:0] dOd  [NM];
    logic [D-1:0] dSv  [NM];
    logic [1:0]   dOcc [NM];
    logic [15:0]  dKc  [NM];

    assign dRdy[0] = ifA.in_ready;  assign dRdy[1] = ifB.in_ready;  assign dRdy[2] = ifC.in_ready;
    assign dOv[0]  = ifA.out_valid; assign dOv[1]  = ifB.out_valid; assign dOv[2]  = ifC.out_valid;
    assign dOd[0]  = ifA.out_data;  assign dOd[1]  = ifB.out_data;  assign dOd[2]  = ifC.out_data;
    assign dSv[0]  = svA;  assign dSv[1]  = svB;  assign dSv[2]  = svC;
    assign dOcc[0] = occA; assign dOcc[1] = occB; assign dOcc[2] = occC;
    assign dKc[0]  = kcA;  assign dKc[1]  = kcB;  assign dKc[2]  = {14'b0, kcC};

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each pipe is an array of word slots. A word moves
    // forward when the spot ahead is free or is itself being vacated
    // (collapsing), or only when the whole line can move (lockstep).
    int           mCollapse [NM] = '{0, 1, 0};
    int           mKillMax  [NM] = '{65535, 65535, 3};
    bit           mV     [NM][D];
    logic [W-1:0] mD     [NM][D];
    int           mKill  [NM];
    bit           mLeave [NM][D];
    bit           mFill  [NM][D];
    bit           mRdy   [NM];

    task automatic modelReset();
        for (int m = 0; m < NM; m++) begin
            mKill[m] = 0;
            for (int i = 0; i < D; i++) begin
                mV[m][i] = 1'b0;
                mD[m][i] = '0;
            end
        end
    endtask

    task automatic modelEval(input int m);
        bit lineMoves;
        bit ahead;
        if (mCollapse[m] == 0) begin
            lineMoves = outReady || !mV[m][D-1];
            for (int i = 0; i < D; i++) begin
                mLeave[m][i] = lineMoves && mV[m][i];
                mFill[m][i]  = lineMoves;
            end
        end else begin
            for (int i = D - 1; i >= 0; i--) begin
                ahead = (i == D - 1) ? outReady : (!mV[m][i+1] || mLeave[m][i+1]);
                mLeave[m][i] = mV[m][i] && ahead;
                mFill[m][i]  = !mV[m][i] || mLeave[m][i];
            end
        end
        mRdy[m] = mFill[m][0];
    endtask

    task automatic modelStep(input int m);
        bit           nv [D];
        logic [W-1:0] nd [D];
        bit           accepted;
        int           kills;
        if (reset) begin
            mKill[m] = 0;
            for (int i = 0; i < D; i++) begin
                mV[m][i] = 1'b0;
                mD[m][i] = '0;
            end
        end else begin
            accepted = inValid && mRdy[m];
            kills = (accepted && flush[0]) ? 1 : 0;
            for (int i = 0; i < D; i++) begin
                if (mV[m][i] && flush[i] && !mLeave[m][i]) kills++;
                if (!mFill[m][i]) begin
                    nv[i] = mV[m][i];
                    nd[i] = mD[m][i];
                end else if (i == 0) begin
                    nv[i] = accepted;
                    nd[i] = accepted ? inData : '0;
                end else begin
                    nv[i] = mLeave[m][i-1];
                    nd[i] = mLeave[m][i-1] ? mD[m][i-1] : '0;
                end
                if (flush[i]) begin
                    nv[i] = 1'b0;
                    nd[i] = '0;
                end
            end
            for (int i = 0; i < D; i++) begin
                mV[m][i] = nv[i];
                mD[m][i] = nd[i];
            end
            mKill[m] = (mKill[m] + kills > mKillMax[m]) ? mKillMax[m] : mKill[m] + kills;
        end
    endtask

    task automatic checkOutputs(input int m);
        logic [D-1:0] sv;
        int           occ;
        occ = 0;
        for (int i = 0; i < D; i++) begin
            sv[i] = mV[m][i];
            occ  += mV[m][i] ? 1 : 0;
        end
        check($sformatf("out_valid%0d", m),   32'(dOv[m]),  32'(mV[m][D-1]));
        check($sformatf("out_data%0d", m),    32'(dOd[m]),  32'(mD[m][D-1]));
        check($sformatf("stage_valid%0d", m), 32'(dSv[m]),  32'(sv));
        check($sformatf("occupancy%0d", m),   32'(dOcc[m]), 32'(occ));
        check($sformatf("kill_count%0d", m),  32'(dKc[m]),  32'(mKill[m]));
    endtask

    task automatic cycle(input bit rst, input bit iv, input logic [W-1:0] id,
                         input logic [D-1:0] fl, input bit ordy);
        @(negedge clk);
        reset = rst; inValid = iv; inData = id; flush = fl; outReady = ordy;
        #1;
        for (int m = 0; m < NM; m++) begin
            modelEval(m);
            check($sformatf("in_ready%0d", m), 32'(dRdy[m]), 32'(mRdy[m]));
            modelStep(m);
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < NM; m++) checkOutputs(m);
    endtask

    initial begin
        reset = 1'b1; inValid = 1'b0; inData = '0; flush = '0; outReady = 1'b1;
        modelReset();
        cycle(1, 0, 0, 3'b000, 1);
        cycle(1, 0, 0, 3'b000, 1);
        check("rst_occ", 32'(dOcc[0]), 32'd0);
        check("rst_sv",  32'(dSv[1]),  32'd0);

        // Back-to-back 1,2,3 with a free consumer.
        for (int k = 1; k <= 6; k++) begin
            cycle(0, k <= 3, W'(k), 3'b000, 1);
            if (k >= 3 && k <= 5) check("t1_out", 32'(dOd[0]), 32'(k - 2));
            if (k == 3) check("t1_occ", 32'(dOcc[0]), 32'd3);
        end

        // Full lockstep pipe under a 2-cycle stall, then drained in order.
        cycle(1, 0, 0, 3'b000, 1);
        for (int k = 0; k < 3; k++) cycle(0, 1, W'(10 + k), 3'b000, 1);
        cycle(0, 1, 4'd13, 3'b000, 0);
        cycle(0, 1, 4'd13, 3'b000, 0);
        check("t2_stall_rdy", 32'(dRdy[0]), 32'd0);
        check("t2_head", 32'(dOd[0]), 32'd10);
        cycle(0, 0, 0, 3'b000, 1);
        check("t2_d1", 32'(dOd[0]), 32'd11);
        cycle(0, 0, 0, 3'b000, 1);
        check("t2_d2", 32'(dOd[0]), 32'd12);
        cycle(0, 0, 0, 3'b000, 1);

        // Collapsing pipe with a hole in the middle: slots {v,0,v}.
        cycle(1, 0, 0, 3'b000, 1);
        cycle(0, 1, 4'd5, 3'b000, 0);
        cycle(0, 0, 0, 3'b000, 0);
        cycle(0, 1, 4'd6, 3'b000, 0);
        check("t3_hole", 32'(dSv[1]), 32'b101);
        cycle(0, 1, 4'd7, 3'b000, 0);
        check("t3_full", 32'(dSv[1]), 32'b111);
        check("t3_rdy",  32'(dRdy[1]), 32'd0);

        // Flush of a middle slot while stalled, then flush of the output slot while delivering.
        cycle(1, 0, 0, 3'b000, 1);
        for (int k = 0; k < 3; k++) cycle(0, 1, W'(1 + k), 3'b000, 1);
        cycle(0, 0, 0, 3'b010, 0);
        check("t4_kill", 32'(dKc[0]), 32'd1);
        check("t4_occ",  32'(dOcc[0]), 32'd2);
        check("t4_sv",   32'(dSv[0]), 32'b101);
        cycle(0, 0, 0, 3'b100, 1);
        check("t4_deliver_kill", 32'(dKc[0]), 32'd1);

        // Accepted-and-dropped inputs saturate the 2-bit counter.
        cycle(1, 0, 0, 3'b000, 1);
        for (int k = 1; k <= 5; k++) begin
            cycle(0, 1, 4'($urandom_range(1, 15)), 3'b001, 1);
            check("t5_sat", 32'(dKc[2]), 32'(k < 3 ? k : 3));
        end

        // Reset with words in flight and a simultaneous full flush.
        for (int k = 0; k < 3; k++) cycle(0, 1, W'(8 + k), 3'b000, 0);
        cycle(1, 1, 4'd15, 3'b111, 0);
        check("t6_sv",   32'(dSv[0]), 32'd0);
        check("t6_out",  32'(dOd[0]), 32'd0);
        check("t6_occ",  32'(dOcc[0]), 32'd0);
        check("t6_kill", 32'(dKc[0]), 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 75,
                  4'($urandom),
                  {$urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8},
                  $urandom_range(0, 99) < 65);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
